// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the CPU instruction-fetch channel and the
// load/store channel. Only one transaction is outstanding at a time. When both
// channels request in the same IDLE cycle, the grant alternates (round-robin).
// The winner's request is forwarded downstream. The single downstream response
// is passed back combinationally to the channel that won.
//
// Build option:
//   ARB_PERF_CNT_EN - when defined, builds the fetch, load/store and conflict
//                     performance counters. When undefined, the perf_* ports
//                     are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   inst_req_* / inst_rsp_* instruction-fetch request/response channel
//   data_* / data_rsp_*    load/store request/response channel
//   mem_req_* / mem_rsp_*  downstream memory port
//   perf_*_cnt             granted fetches, granted loads/stores, conflict cycles
//
// state  | meaning
// IDLE   | no transaction; arbitrate between the two channels
// I_REQ  | fetch request presented downstream
// I_RSP  | waiting for / returning fetch data
// D_REQ  | load or store request presented downstream
// D_RSP  | waiting for / returning load data
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_req_valid,
  output logic                    inst_req_ack,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic [DATA_WIDTH-1:0]   inst_rsp_data,
  output logic                    inst_rsp_valid,
  input  logic                    inst_rsp_ack,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_req_ack,
  output logic [DATA_WIDTH-1:0]   data_rsp_data,
  output logic                    data_rsp_valid,
  input  logic                    data_rsp_ack,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_wr,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [31:0]             perf_inst_cnt,
  output logic [31:0]             perf_data_cnt,
  output logic [31:0]             perf_conflict_cnt
);

  typedef enum logic [2:0] {IDLE, I_REQ, I_RSP, D_REQ, D_RSP} state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   data_pending;

  assign data_pending = data_read | data_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      // Reset to DATA so that the first conflict goes to the fetch channel.
      last_grant_q <= GRANT_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    inst_req_ack   = 1'b0;
    inst_rsp_data  = '0;
    inst_rsp_valid = 1'b0;
    data_req_ack   = 1'b0;
    data_rsp_data  = '0;
    data_rsp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_wr     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mem_req_wstrb  = '0;
    mem_rsp_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (inst_req_valid && data_pending) begin
          if (last_grant_q == GRANT_DATA) begin
            state_d      = I_REQ;
            last_grant_d = GRANT_INST;
          end else begin
            state_d      = D_REQ;
            last_grant_d = GRANT_DATA;
          end
        end else if (inst_req_valid) begin
          state_d      = I_REQ;
          last_grant_d = GRANT_INST;
        end else if (data_pending) begin
          state_d      = D_REQ;
          last_grant_d = GRANT_DATA;
        end
      end

      I_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = inst_addr;
        inst_req_ack  = mem_req_ready;
        if (mem_req_ready) state_d = I_RSP;
      end

      I_RSP: begin
        inst_rsp_valid = mem_rsp_valid;
        inst_rsp_data  = mem_rsp_data;
        mem_rsp_ready  = inst_rsp_ack;
        if (mem_rsp_valid && inst_rsp_ack) state_d = IDLE;
      end

      D_REQ: begin
        // A request with both read and write set is handled as a write.
        mem_req_valid = 1'b1;
        mem_req_wr    = data_write;
        mem_req_addr  = data_addr;
        mem_req_wdata = data_wdata;
        mem_req_wstrb = data_write ? data_wstrb : '0;
        data_req_ack  = mem_req_ready;
        // A store has no response phase.
        if (mem_req_ready) state_d = data_write ? IDLE : D_RSP;
      end

      D_RSP: begin
        data_rsp_valid = mem_rsp_valid;
        data_rsp_data  = mem_rsp_data;
        mem_rsp_ready  = data_rsp_ack;
        if (mem_rsp_valid && data_rsp_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = (state_q == IDLE) && inst_req_valid && data_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_cnt     <= '0;
      perf_data_cnt     <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (state_q == I_REQ && mem_req_ready) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (state_q == D_REQ && mem_req_ready) perf_data_cnt <= perf_data_cnt + 32'd1;
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  assign perf_inst_cnt     = '0;
  assign perf_data_cnt     = '0;
  assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_valid, inst_req_ack, inst_rsp_valid, inst_rsp_ack;
  logic [31:0] inst_addr, inst_rsp_data;
  logic        data_read, data_write, data_req_ack, data_rsp_valid, data_rsp_ack;
  logic [31:0] data_addr, data_wdata, data_rsp_data;
  logic [3:0]  data_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_wr, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] perf_inst_cnt, perf_data_cnt, perf_conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ack(inst_req_ack), .inst_addr(inst_addr),
    .inst_rsp_data(inst_rsp_data), .inst_rsp_valid(inst_rsp_valid), .inst_rsp_ack(inst_rsp_ack),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ack(data_req_ack),
    .data_rsp_data(data_rsp_data), .data_rsp_valid(data_rsp_valid), .data_rsp_ack(data_rsp_ack),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_req_valid = 1'b0; inst_addr = '0; inst_rsp_ack = 1'b0;
    data_read = 1'b0; data_write = 1'b0; data_addr = '0; data_wdata = '0;
    data_wstrb = '0; data_rsp_ack = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    chk("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("reset_perf_inst", perf_inst_cnt, 32'd0);

    // Single fetch
    rst = 1'b0;
    inst_req_valid = 1'b1; inst_addr = 32'h100;
    settle();
    chk("fetch_idle_bubble", 32'(mem_req_valid), 32'd0);
    step();
    chk("fetch_req_valid", 32'(mem_req_valid), 32'd1);
    chk("fetch_req_addr", mem_req_addr, 32'h100);
    chk("fetch_req_wr", 32'(mem_req_wr), 32'd0);
    chk("fetch_ack_not_ready", 32'(inst_req_ack), 32'd0);
    mem_req_ready = 1'b1;
    settle();
    chk("fetch_ack_ready", 32'(inst_req_ack), 32'd1);
    step();
    inst_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00500093; inst_rsp_ack = 1'b1;
    settle();
    chk("fetch_rsp_valid", 32'(inst_rsp_valid), 32'd1);
    chk("fetch_rsp_data", inst_rsp_data, 32'h00500093);
    chk("fetch_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    chk("fetch_no_data_rsp", 32'(data_rsp_valid), 32'd0);
    step();
    mem_rsp_valid = 1'b0; inst_rsp_ack = 1'b0;
    settle();
    chk("fetch_back_idle", 32'(inst_rsp_valid), 32'd0);
    chk("fetch_perf_inst", perf_inst_cnt, PERF ? 32'd1 : 32'd0);

    // Store
    data_write = 1'b1; data_addr = 32'h2000; data_wdata = 32'hDEADBEEF; data_wstrb = 4'h3;
    mem_req_ready = 1'b1;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11111111; data_rsp_ack = 1'b1;
    settle();
    chk("store_req_valid", 32'(mem_req_valid), 32'd1);
    chk("store_req_wr", 32'(mem_req_wr), 32'd1);
    chk("store_req_addr", mem_req_addr, 32'h2000);
    chk("store_req_wdata", mem_req_wdata, 32'hDEADBEEF);
    chk("store_req_wstrb", 32'(mem_req_wstrb), 32'h3);
    chk("store_req_ack", 32'(data_req_ack), 32'd1);
    chk("store_rsp_ready_in_req", 32'(mem_rsp_ready), 32'd0);
    step();
    data_write = 1'b0; mem_req_ready = 1'b0;
    settle();
    chk("store_idle_req_valid", 32'(mem_req_valid), 32'd0);
    chk("store_idle_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("store_idle_rsp_valid", 32'(data_rsp_valid), 32'd0);
    chk("store_perf_data", perf_data_cnt, PERF ? 32'd1 : 32'd0);
    mem_rsp_valid = 1'b0; data_rsp_ack = 1'b0;

    // Conflict / round-robin, requests held from reset
    rst = 1'b1;
    inst_req_valid = 1'b1; inst_addr = 32'h200;
    data_read = 1'b1; data_addr = 32'h40;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5A5A5;
    inst_rsp_ack = 1'b1; data_rsp_ack = 1'b1;
    step();
    chk("rr_reset_perf_data", perf_data_cnt, 32'd0);
    chk("rr_reset_outputs", 32'(mem_req_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("rr_grant1_inst", 32'(inst_req_ack), 32'd1);
    chk("rr_grant1_addr", mem_req_addr, 32'h200);
    chk("rr_grant1_no_data", 32'(data_req_ack), 32'd0);
    step(); step(); step();
    chk("rr_grant2_data", 32'(data_req_ack), 32'd1);
    chk("rr_grant2_addr", mem_req_addr, 32'h40);
    chk("rr_grant2_wstrb", 32'(mem_req_wstrb), 32'h0);
    chk("rr_grant2_no_inst", 32'(inst_req_ack), 32'd0);
    step(); step(); step();
    chk("rr_grant3_inst", 32'(inst_req_ack), 32'd1);
    chk("rr_grant3_addr", mem_req_addr, 32'h200);
    chk("rr_conflict_cnt", perf_conflict_cnt, PERF ? 32'd3 : 32'd0);
    chk("rr_perf_inst", perf_inst_cnt, PERF ? 32'd1 : 32'd0);
    chk("rr_perf_data", perf_data_cnt, PERF ? 32'd1 : 32'd0);
    step();
    // Now in I_RSP: reset mid-operation
    inst_req_valid = 1'b0; data_read = 1'b0;
    settle();
    chk("midrst_in_rsp", 32'(inst_rsp_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_rsp_valid", 32'(inst_rsp_valid), 32'd0);
    chk("midrst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("midrst_rsp_data", inst_rsp_data, 32'd0);
    chk("midrst_perf_inst", perf_inst_cnt, 32'd0);
    chk("midrst_perf_conf", perf_conflict_cnt, 32'd0);
    rst = 1'b0;
    idle_inputs();
    inst_req_valid = 1'b1; inst_addr = 32'h104; mem_req_ready = 1'b1;
    step();
    chk("postrst_req_addr", mem_req_addr, 32'h104);
    chk("postrst_req_ack", 32'(inst_req_ack), 32'd1);
    step();
    inst_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678; inst_rsp_ack = 1'b1;
    settle();
    chk("postrst_rsp_data", inst_rsp_data, 32'h12345678);
    step();
    idle_inputs();
    settle();
    chk("postrst_idle", 32'(inst_rsp_valid), 32'd0);
    chk("postrst_perf_inst", perf_inst_cnt, PERF ? 32'd1 : 32'd0);

    // Backpressure on a load
    data_read = 1'b1; data_addr = 32'h40;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_req_addr", mem_req_addr, 32'h40);
      chk("bp_req_ack", 32'(data_req_ack), 32'd0);
      step();
    end
    mem_req_ready = 1'b1;
    settle();
    chk("bp_req_ack_ready", 32'(data_req_ack), 32'd1);
    chk("bp_req_wr", 32'(mem_req_wr), 32'd0);
    step();
    data_read = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D; data_rsp_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_rsp_ready_held", 32'(mem_rsp_ready), 32'd0);
      chk("bp_rsp_valid", 32'(data_rsp_valid), 32'd1);
      chk("bp_rsp_data", data_rsp_data, 32'hCAFEF00D);
      step();
    end
    data_rsp_ack = 1'b1;
    settle();
    chk("bp_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    step();
    idle_inputs();
    settle();
    chk("bp_back_idle", 32'(data_rsp_valid), 32'd0);
    chk("bp_perf_data", perf_data_cnt, PERF ? 32'd1 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the multicycle CPU's instruction-fetch channel and its load/store channel.
- Sits between the CPU and the memory/bus bridge.
- Latches which requester won, forwards its request, and routes the single downstream response back to that requester.
- Round-robin grant when both channels request in the same cycle; one outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
inst_req_valid  input  1  CPU fetch request
inst_req_ack  output  1  fetch request accepted
inst_addr  input  ADDR_WIDTH  fetch address (PC), held stable while inst_req_valid
inst_rsp_data  output  DATA_WIDTH  fetched instruction
inst_rsp_valid  output  1  instruction valid
inst_rsp_ack  input  1  CPU takes instruction
data_read  input  1  load request
data_write  input  1  store request
data_addr  input  ADDR_WIDTH  word-aligned load/store address
data_wdata  input  DATA_WIDTH  store data
data_wstrb  input  DATA_WIDTH/8  store byte strobes
data_req_ack  output  1  load/store request accepted
data_rsp_data  output  DATA_WIDTH  load data
data_rsp_valid  output  1  load data valid
data_rsp_ack  input  1  CPU takes load data
mem_req_valid  output  1  downstream request
mem_req_ready  input  1  downstream accepts request
mem_req_wr  output  1  1 = write, 0 = read
mem_req_addr  output  ADDR_WIDTH  downstream address
mem_req_wdata  output  DATA_WIDTH  downstream write data
mem_req_wstrb  output  DATA_WIDTH/8  downstream strobes, 0 on reads
mem_rsp_valid  input  1  downstream read data valid
mem_rsp_ready  output  1  arbiter accepts read data
mem_rsp_data  input  DATA_WIDTH  downstream read data
perf_inst_cnt  output  32  granted fetches
perf_data_cnt  output  32  granted loads and stores
perf_conflict_cnt  output  32  cycles in IDLE with both channels requesting

Behaviour:
- A transfer on any channel occurs in a cycle where its valid/ack (or valid/ready) pair is both 1.
- States: IDLE, I_REQ, I_RSP, D_REQ, D_RSP. Reset -> IDLE.
- Reset values:
  - all outputs 0.
  - last_grant = DATA, so the first conflict grants INST.
- IDLE: all outputs 0.
  - data_pending = data_read | data_write.
  - Only inst_req_valid -> I_REQ.
  - Only data_pending -> D_REQ.
  - Both -> grant the channel not equal to last_grant; count a conflict cycle.
  - Update last_grant on every grant.
- I_REQ:
  - mem_req_valid=1, mem_req_wr=0, mem_req_addr=inst_addr, mem_req_wstrb=0.
  - inst_req_ack=mem_req_ready (combinational).
  - On handshake -> I_RSP.
- I_RSP:
  - inst_rsp_valid=mem_rsp_valid, inst_rsp_data=mem_rsp_data, mem_rsp_ready=inst_rsp_ack.
  - On handshake -> IDLE.
- D_REQ:
  - mem_req_valid=1, mem_req_wr=data_write, addr/wdata/wstrb driven from the data channel.
  - data_req_ack=mem_req_ready.
  - On handshake: write -> IDLE (no response phase); read -> D_RSP.
- D_RSP: same as I_RSP but on the data channel; on handshake -> IDLE.
- The request is captured in a grant register, not re-arbitrated.
  - Deasserting upstream valid mid-state is a protocol violation; the arbiter stays in its state.
- data_read and data_write both 1: treated as a write.
- Latency:
  - one idle bubble: a request raised in cycle N sees mem_req_valid in N+1.
  - back-to-back transactions have >= 1 IDLE cycle between them.
- mem_rsp_ready=0 outside the *_RSP states. Responses in other states are not consumed.
- rst in any state:
  - -> IDLE next cycle, and all outputs 0 in that cycle.
  - The downstream memory is reset in the same cycle; no in-flight response is tracked.
- Response data is combinational pass-through; the arbiter has no data storage.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - perf_inst_cnt / perf_data_cnt increment by 1 on each request handshake of their channel.
  - perf_conflict_cnt increments on each IDLE cycle with both channels requesting.
  - All three clear to 0 on rst and wrap at 2^32.
- Not defined: the three ports remain and are tied to 0; no counter flops are synthesized.

Test Plan:
- Single fetch: inst_req_valid=1, inst_addr=0x100, mem_req_ready=1 one cycle later -> mem_req_addr=0x100, mem_req_wr=0.
  - Then mem_rsp_valid with data 0x00500093 -> inst_rsp_data=0x00500093, inst_rsp_valid=1; back to IDLE after inst_rsp_ack.
- Store: data_write=1, data_addr=0x2000, data_wdata=0xDEADBEEF, data_wstrb=0x3.
  - -> mem_req_wr=1, mem_req_wstrb=0x3, data_req_ack on ready; IDLE next cycle with mem_rsp_ready held 0.
- Conflict, round-robin: inst_req_valid and data_read both held from reset.
  - -> grants INST, DATA, INST in that order.
  - perf_conflict_cnt=3 with ARB_PERF_CNT_EN; 0 without.
- Backpressure: mem_req_ready=0 for 5 cycles during D_REQ (load 0x40).
  - -> mem_req_valid and address held; data_req_ack=0 until ready.
  - mem_rsp_valid with data_rsp_ack=0 for 3 cycles -> mem_rsp_ready=0 for those cycles.
- Reset mid-operation: rst=1 while in I_RSP.
  - -> next cycle all outputs 0, state IDLE, perf counters 0.
  - The following fetch completes normally.
